// File: rtl/dmi_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dmi_core_sequencer
// Description : Core-clock sequencer sitting behind the DMI clock-domain
//               crossing. Accepts one DMI request at a time, forwards READ/WRITE
//               requests to the debug module, waits for the DM response with a
//               bounded timeout, and returns exactly one response per accepted
//               request so the JTAG side can never hang on a silent DM.
//
// Ports       : clk_i            core clock
//               rst_i            synchronous active-high reset
//               cdc_req_i        {addr[6:0], op[1:0], data[31:0]} from CDC
//               cdc_req_valid_i  / cdc_req_ready_o    request handshake
//               cdc_resp_o       {data[31:0], resp[1:0]} to CDC
//               cdc_resp_valid_o / cdc_resp_ready_i   response handshake
//               dm_req_o         request to DM
//               dm_req_valid_o   / dm_req_ready_i     DM request handshake
//               dm_resp_i        DM response
//               dm_resp_valid_i  / dm_resp_ready_o    DM response handshake
//               busy_o           high whenever not idle
//               timeout_cnt_o    saturating count of timed-out transactions
//               stray_cnt_o      saturating count of unsolicited DM responses
//
// Revision    : 1.0  initial release
// ============================================================================
module dmi_core_sequencer #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [40:0] cdc_req_i,
    input  logic        cdc_req_valid_i,
    output logic        cdc_req_ready_o,
    output logic [33:0] cdc_resp_o,
    output logic        cdc_resp_valid_o,
    input  logic        cdc_resp_ready_i,
    output logic [40:0] dm_req_o,
    output logic        dm_req_valid_o,
    input  logic        dm_req_ready_i,
    input  logic [33:0] dm_resp_i,
    input  logic        dm_resp_valid_i,
    output logic        dm_resp_ready_o,
    output logic        busy_o,
    output logic [7:0]  timeout_cnt_o,
    output logic [7:0]  stray_cnt_o
);

    localparam int unsigned CNT_W = $clog2(TimeoutCycles + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0]       c_op_nop     = 2'd0;
    localparam logic [1:0]       c_op_rsvd    = 2'd3;
    localparam logic [33:0]      c_resp_ok    = 34'd0;
    localparam logic [33:0]      c_resp_err   = {32'h0, 2'b10};
    localparam logic [CNT_W-1:0] c_timer_last = CNT_W'(TimeoutCycles - 1);
    localparam logic [7:0]       c_cnt_max    = 8'hFF;

    logic [1:0]       r_state;
    logic [40:0]      r_req;
    logic [33:0]      r_resp;
    logic [CNT_W-1:0] r_timer;
    logic [7:0]       r_timeout_cnt;
    logic [7:0]       r_stray_cnt;

    logic [1:0]       w_op;

    assign w_op = cdc_req_i[33:32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_req         <= '0;
            r_resp        <= '0;
            r_timer       <= '0;
            r_timeout_cnt <= '0;
            r_stray_cnt   <= '0;
        end else begin
            // The DM response channel is always ready; anything arriving
            // outside WAIT has no transaction to belong to and is dropped.
            if (dm_resp_valid_i && (r_state != S_WAIT) && (r_stray_cnt != c_cnt_max)) begin
                r_stray_cnt <= r_stray_cnt + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cdc_req_valid_i) begin
                        r_req   <= cdc_req_i;
                        r_timer <= '0;
                        if (w_op == c_op_nop) begin
                            r_resp  <= c_resp_ok;
                            r_state <= S_RESP;
                        end else if (w_op == c_op_rsvd) begin
                            r_resp  <= c_resp_err;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end

                // The timer also guards the request phase so a DM that never
                // accepts cannot stall the sequencer.
                S_ISSUE: begin
                    if (dm_req_ready_i) begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end else if (r_timer == c_timer_last) begin
                        r_resp  <= c_resp_err;
                        r_state <= S_RESP;
                        if (r_timeout_cnt != c_cnt_max) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // A response on the last permitted cycle still wins over the
                // timeout.
                S_WAIT: begin
                    if (dm_resp_valid_i) begin
                        r_resp  <= dm_resp_i;
                        r_state <= S_RESP;
                    end else if (r_timer == c_timer_last) begin
                        r_resp  <= c_resp_err;
                        r_state <= S_RESP;
                        if (r_timeout_cnt != c_cnt_max) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_RESP: begin
                    if (cdc_resp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready outputs are decoded from state and held low while reset is
    // applied; no handshake input reaches any output combinationally.
    assign cdc_req_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign dm_resp_ready_o  = !rst_i;
    assign dm_req_valid_o   = (r_state == S_ISSUE);
    assign cdc_resp_valid_o = (r_state == S_RESP);
    assign busy_o           = (r_state != S_IDLE);
    assign dm_req_o         = r_req;
    assign cdc_resp_o       = r_resp;
    assign timeout_cnt_o    = r_timeout_cnt;
    assign stray_cnt_o      = r_stray_cnt;

endmodule
`default_nettype wire
